// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues one command at a time to a combinational ALU and holds
// its operands for SETTLE cycles. It then returns the captured result and flags.
module alu_cmd_sequencer #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [2:0]       cmd_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_zero,
    input  logic             alu_negative,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       sticky_flags,
    input  logic             sticky_clr,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0]       SettleLoad = 4'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CntOne     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic [3:0]       settle_cnt_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [2:0]       alu_control_q;
    logic [WIDTH-1:0] rsp_result_q;
    logic [3:0]       rsp_flags_q;
    logic [3:0]       sticky_q;
    logic [CNT_W-1:0] op_count_q;

    logic [3:0] flags_d;
    logic       capture_d;

    assign flags_d   = {alu_negative, alu_zero, alu_carry, alu_overflow};
    assign capture_d = (state_q == WAIT) && (settle_cnt_q == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            settle_cnt_q  <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_control_q <= '0;
            rsp_result_q  <= '0;
            rsp_flags_q   <= '0;
            sticky_q      <= '0;
            op_count_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_a_q       <= cmd_a;
                        alu_b_q       <= cmd_b;
                        alu_control_q <= cmd_op;
                        settle_cnt_q  <= SettleLoad;
                        state_q       <= WAIT;
                    end
                end
                WAIT: begin
                    if (settle_cnt_q != 4'd0) begin
                        settle_cnt_q <= settle_cnt_q - 4'd1;
                    end else begin
                        rsp_result_q <= alu_result;
                        rsp_flags_q  <= flags_d;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        op_count_q <= op_count_q + CntOne;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A capture on the same edge as a clear keeps the freshly captured flags.
            if (capture_d) begin
                sticky_q <= sticky_clr ? flags_d : (sticky_q | flags_d);
            end else if (sticky_clr) begin
                sticky_q <= '0;
            end
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_control  = alu_control_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_flags    = rsp_flags_q;
    assign sticky_flags = sticky_q;
    assign op_count     = op_count_q;

endmodule
